// File: rtl/vend_txn_controller_if.sv
// Handshake/bus bundle between the vending front end (master) and vend_txn_controller (slave).
interface vend_txn_controller_if #(
    parameter int unsigned CW = 4
);
    logic [3:0]    item_number;
    logic          item_valid;
    logic          rs_5_in;
    logic          rs_10_in;
    logic          cancel;
    logic          dispense_ack;
    logic          dispense;
    logic          rs_5_out;
    logic          coin_reject;
    logic          sel_error;
    logic          busy;
    logic [CW-1:0] credit;
    logic          timeout;

    modport master (
        output item_number, item_valid, rs_5_in, rs_10_in, cancel, dispense_ack,
        input  dispense, rs_5_out, coin_reject, sel_error, busy, credit, timeout
    );

    modport slave (
        input  item_number, item_valid, rs_5_in, rs_10_in, cancel, dispense_ack,
        output dispense, rs_5_out, coin_reject, sel_error, busy, credit, timeout
    );
endinterface

// File: rtl/vend_txn_controller.sv
// Shared single-transaction vending sequencer: select, collect, dispense, then change/refund pulses.
// Optional COLLECT inactivity auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_txn_controller #(
    parameter int unsigned PRICE1         = 3,
    parameter int unsigned PRICE2         = 4,
    parameter int unsigned PRICE3         = 5,
    parameter int unsigned PRICE4         = 6,
    parameter int unsigned CW             = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                  clock,
    input logic                  reset,
    vend_txn_controller_if.slave bus
);

    localparam int unsigned PRICE_MAX_12 = (PRICE1 > PRICE2) ? PRICE1 : PRICE2;
    localparam int unsigned PRICE_MAX_34 = (PRICE3 > PRICE4) ? PRICE3 : PRICE4;
    localparam int unsigned PRICE_MAX    = (PRICE_MAX_12 > PRICE_MAX_34) ? PRICE_MAX_12 : PRICE_MAX_34;

    // Credit can overshoot the price by two units before the threshold is seen.
    if ((CW < 2) || ((2 ** CW) <= (PRICE_MAX + 2))) begin : g_cw_check
        $error("vend_txn_controller: CW too narrow for max price + 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("vend_txn_controller: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4
    } state_e;

    function automatic logic is_one_hot(input logic [3:0] code);
        case (code)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [CW-1:0] price_of(input logic [3:0] code);
        case (code)
            4'b0001: return CW'(PRICE1);
            4'b0010: return CW'(PRICE2);
            4'b0100: return CW'(PRICE3);
            4'b1000: return CW'(PRICE4);
            default: return {CW{1'b0}};
        endcase
    endfunction

    state_e        state_q;
    logic [CW-1:0] credit_q;
    logic [CW-1:0] change_q;
    logic [CW-1:0] price_q;
    logic          dispense_q;
    logic          rs_5_out_q;
    logic          coin_reject_q;
    logic          sel_error_q;
    logic          busy_q;

    logic          coin_any_s;
    logic [CW-1:0] coin_units_s;
    logic [CW-1:0] credit_d;
    logic [CW-1:0] change_d;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] idle_cnt_q;
    logic          timeout_q;
`endif

    // Coin value and the credit/change a coin would produce this cycle.
    always_comb begin
        coin_any_s   = bus.rs_5_in | bus.rs_10_in;
        coin_units_s = {{(CW-2){1'b0}}, bus.rs_10_in, 1'b0} + {{(CW-1){1'b0}}, bus.rs_5_in};
        credit_d     = credit_q + coin_units_s;
        change_d     = credit_d - price_q;
    end

    // Transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            credit_q      <= {CW{1'b0}};
            change_q      <= {CW{1'b0}};
            price_q       <= {CW{1'b0}};
            dispense_q    <= 1'b0;
            rs_5_out_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_error_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            idle_cnt_q    <= {TW{1'b0}};
            timeout_q     <= 1'b0;
`endif
        end else begin
            rs_5_out_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_error_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    coin_reject_q <= coin_any_s;
                    if (bus.item_valid) begin
                        if (is_one_hot(bus.item_number)) begin
                            price_q  <= price_of(bus.item_number);
                            credit_q <= {CW{1'b0}};
                            busy_q   <= 1'b1;
                            state_q  <= S_COLLECT;
`ifdef VEND_TIMEOUT_EN
                            idle_cnt_q <= {TW{1'b0}};
`endif
                        end else begin
                            sel_error_q <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (bus.cancel) begin
                        // A coin arriving together with cancel is handed back, not credited.
                        coin_reject_q <= coin_any_s;
                        if (credit_q != {CW{1'b0}}) begin
                            change_q   <= credit_q - CW'(1);
                            credit_q   <= {CW{1'b0}};
                            rs_5_out_q <= 1'b1;
                            state_q    <= S_REFUND;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else if (coin_any_s) begin
`ifdef VEND_TIMEOUT_EN
                        idle_cnt_q <= {TW{1'b0}};
`endif
                        if (credit_d >= price_q) begin
                            change_q   <= change_d;
                            credit_q   <= {CW{1'b0}};
                            dispense_q <= 1'b1;
                            state_q    <= S_DISPENSE;
                        end else begin
                            credit_q <= credit_d;
                        end
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        if (credit_q != {CW{1'b0}}) begin
                            change_q   <= credit_q - CW'(1);
                            credit_q   <= {CW{1'b0}};
                            rs_5_out_q <= 1'b1;
                            state_q    <= S_REFUND;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + TW'(1);
                    end
`endif
                end

                S_DISPENSE: begin
                    coin_reject_q <= coin_any_s;
                    if (bus.dispense_ack) begin
                        dispense_q <= 1'b0;
                        if (change_q != {CW{1'b0}}) begin
                            change_q   <= change_q - CW'(1);
                            rs_5_out_q <= 1'b1;
                            state_q    <= S_CHANGE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_CHANGE, S_REFUND: begin
                    // change_q counts pulses still owed after the one currently high.
                    coin_reject_q <= coin_any_s;
                    if (!rs_5_out_q) begin
                        if (change_q == {CW{1'b0}}) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            change_q   <= change_q - CW'(1);
                            rs_5_out_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    credit_q   <= {CW{1'b0}};
                    change_q   <= {CW{1'b0}};
                    dispense_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dispense    = dispense_q;
    assign bus.rs_5_out    = rs_5_out_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_error   = sel_error_q;
    assign bus.busy        = busy_q;
    assign bus.credit      = credit_q;
`ifdef VEND_TIMEOUT_EN
    assign bus.timeout     = timeout_q;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller: directed scenarios plus randomized transactions
// checked against a transaction-level model (credit sums, change = paid - price, 2 cycles per coin out).
module tb_vend_txn_controller;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 1000;
`endif

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   prices [4] = '{3, 4, 5, 6};

    vend_txn_controller_if #(.CW(4)) bus ();

    vend_txn_controller #(
        .PRICE1(3), .PRICE2(4), .PRICE3(5), .PRICE4(6), .CW(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic select(input logic [3:0] code);
        bus.item_number = code;
        bus.item_valid  = 1'b1;
        tick();
        bus.item_valid  = 1'b0;
        bus.item_number = 4'd0;
    endtask

    task automatic coin(input logic r5, input logic r10);
        bus.rs_5_in  = r5;
        bus.rs_10_in = r10;
        tick();
        bus.rs_5_in  = 1'b0;
        bus.rs_10_in = 1'b0;
    endtask

    // Observe a coin-out train from the current cycle until busy falls (bounded).
    task automatic count_train(output int pulses, output int cycles, output bit disp_seen, output bit expired);
        pulses = 0; cycles = 0; disp_seen = 1'b0; expired = 1'b0;
        while (bus.busy === 1'b1) begin
            if (cycles >= 64) begin
                expired = 1'b1;
                break;
            end
            pulses += (bus.rs_5_out === 1'b1) ? 1 : 0;
            disp_seen |= (bus.dispense === 1'b1);
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.dispense, bus.rs_5_out, bus.coin_reject, bus.sel_error, bus.busy, bus.timeout} !== 6'd0)
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.dispense, bus.rs_5_out, bus.coin_reject, bus.sel_error, bus.busy, bus.timeout});
        else n_pass++;
        n_checks++;
        if (bus.credit !== 4'd0) $display("FAIL reset_credit: got %0d expected 0", bus.credit);
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_exact_pay();
        int p, c; bit d, e;
        select(4'b0001);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL exact_busy: got %b expected 1", bus.busy); else n_pass++;
        coin(1'b0, 1'b1);
        n_checks++;
        if (bus.credit !== 4'd2) $display("FAIL exact_credit2: got %0d expected 2", bus.credit); else n_pass++;
        coin(1'b1, 1'b0);
        n_checks++;
        if (bus.dispense !== 1'b1 || bus.credit !== 4'd0)
            $display("FAIL exact_dispense: got disp=%b credit=%0d expected disp=1 credit=0", bus.dispense, bus.credit);
        else n_pass++;
        tick();
        bus.dispense_ack = 1'b1;
        tick();
        bus.dispense_ack = 1'b0;
        n_checks++;
        if (bus.dispense !== 1'b0) $display("FAIL exact_ack_drop: got %b expected 0", bus.dispense); else n_pass++;
        count_train(p, c, d, e);
        n_checks++;
        if (p !== 0 || e || bus.busy !== 1'b0)
            $display("FAIL exact_no_change: got pulses=%0d busy=%b expected pulses=0 busy=0", p, bus.busy);
        else n_pass++;
    endtask

    task automatic test_change();
        int p, c; bit d, e;
        select(4'b0001);
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        n_checks++;
        if (bus.dispense !== 1'b1) $display("FAIL change_dispense: got %b expected 1", bus.dispense); else n_pass++;
        bus.dispense_ack = 1'b1;
        tick();
        bus.dispense_ack = 1'b0;
        count_train(p, c, d, e);
        n_checks++;
        if (p !== 1 || c !== 2 || e)
            $display("FAIL change_pulses: got pulses=%0d cycles=%0d expected pulses=1 cycles=2", p, c);
        else n_pass++;
    endtask

    task automatic test_refund();
        int p, c; bit d, e;
        select(4'b1000);
        repeat (3) coin(1'b1, 1'b0);
        n_checks++;
        if (bus.credit !== 4'd3) $display("FAIL refund_credit: got %0d expected 3", bus.credit); else n_pass++;
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        count_train(p, c, d, e);
        n_checks++;
        if (p !== 3 || c !== 6 || d || e)
            $display("FAIL refund_train: got pulses=%0d cycles=%0d disp=%b expected pulses=3 cycles=6 disp=0", p, c, d);
        else n_pass++;
        n_checks++;
        if (bus.timeout !== 1'b0) $display("FAIL refund_no_timeout: got %b expected 0", bus.timeout); else n_pass++;
    endtask

    task automatic test_errors();
        select(4'b0110);
        n_checks++;
        if (bus.sel_error !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL sel_error_multi: got sel=%b busy=%b expected sel=1 busy=0", bus.sel_error, bus.busy);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.sel_error !== 1'b0) $display("FAIL sel_error_pulse: got %b expected 0", bus.sel_error); else n_pass++;
        select(4'b0000);
        n_checks++;
        if (bus.sel_error !== 1'b1) $display("FAIL sel_error_zero: got %b expected 1", bus.sel_error); else n_pass++;
        coin(1'b1, 1'b0);
        n_checks++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 4'd0 || bus.busy !== 1'b0)
            $display("FAIL idle_coin_reject: got rej=%b credit=%0d busy=%b expected rej=1 credit=0 busy=0",
                     bus.coin_reject, bus.credit, bus.busy);
        else n_pass++;
    endtask

    task automatic test_dual_coin_ack_hold();
        int p, c; bit d, e;
        select(4'b0010);
        coin(1'b1, 1'b1);
        n_checks++;
        if (bus.credit !== 4'd3) $display("FAIL dual_credit: got %0d expected 3", bus.credit); else n_pass++;
        coin(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.rs_10_in = (i == 2);
            tick();
            bus.rs_10_in = 1'b0;
            n_checks++;
            if (bus.dispense !== 1'b1 || bus.coin_reject !== (i == 2) || bus.credit !== 4'd0)
                $display("FAIL ack_hold_%0d: got disp=%b rej=%b credit=%0d expected disp=1 rej=%b credit=0",
                         i, bus.dispense, bus.coin_reject, bus.credit, (i == 2));
            else n_pass++;
        end
        bus.dispense_ack = 1'b1;
        tick();
        bus.dispense_ack = 1'b0;
        count_train(p, c, d, e);
        n_checks++;
        if (p !== 0 || e) $display("FAIL dual_no_change: got pulses=%0d expected 0", p); else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int idx, price, total, it, cancel_at, k, p, c;
            bit do_cancel, cancelled, d, e;
            logic r5, r10;
            idx       = $urandom_range(0, 3);
            price     = prices[idx];
            do_cancel = ($urandom_range(0, 3) == 0);
            cancel_at = $urandom_range(0, 3);
            total = 0; it = 0; cancelled = 1'b0;
            select(4'b0001 << idx);
            while (total < price && it < 40) begin
                r5  = $urandom_range(0, 1);
                r10 = $urandom_range(0, 1);
                if (do_cancel && it == cancel_at) begin
                    bus.cancel = 1'b1;
                    coin(r5, r10);
                    bus.cancel = 1'b0;
                    n_checks++;
                    if (bus.coin_reject !== (r5 | r10))
                        $display("FAIL rnd%0d_cancel_reject: got %b expected %b", t, bus.coin_reject, r5 | r10);
                    else n_pass++;
                    cancelled = 1'b1;
                    break;
                end
                bus.item_valid  = $urandom_range(0, 1);
                bus.item_number = 4'($urandom_range(0, 15));
                coin(r5, r10);
                bus.item_valid  = 1'b0;
                total += int'(r5) + 2 * int'(r10);
                n_checks++;
                if (total >= price) begin
                    if (bus.dispense !== 1'b1 || bus.credit !== 4'd0 || bus.sel_error !== 1'b0)
                        $display("FAIL rnd%0d_reach: got disp=%b credit=%0d expected disp=1 credit=0",
                                 t, bus.dispense, bus.credit);
                    else n_pass++;
                end else begin
                    if (bus.dispense !== 1'b0 || bus.credit !== 4'(total) || bus.coin_reject !== 1'b0
                        || bus.sel_error !== 1'b0 || bus.timeout !== 1'b0)
                        $display("FAIL rnd%0d_credit: got credit=%0d disp=%b expected credit=%0d disp=0",
                                 t, bus.credit, bus.dispense, total);
                    else n_pass++;
                end
                it++;
            end
            if (cancelled) begin
                count_train(p, c, d, e);
                n_checks++;
                if (p !== total || c !== 2 * total || d || e || bus.busy !== 1'b0)
                    $display("FAIL rnd%0d_refund: got pulses=%0d cycles=%0d expected pulses=%0d cycles=%0d",
                             t, p, c, total, 2 * total);
                else n_pass++;
            end else begin
                k = $urandom_range(0, 3);
                repeat (k) tick();
                n_checks++;
                if (bus.dispense !== 1'b1) $display("FAIL rnd%0d_hold: got %b expected 1", t, bus.dispense);
                else n_pass++;
                bus.dispense_ack = 1'b1;
                tick();
                bus.dispense_ack = 1'b0;
                count_train(p, c, d, e);
                n_checks++;
                if (p !== total - price || c !== 2 * (total - price) || d || e)
                    $display("FAIL rnd%0d_change: got pulses=%0d cycles=%0d expected pulses=%0d cycles=%0d",
                             t, p, c, total - price, 2 * (total - price));
                else n_pass++;
            end
            tick();
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        int n, p, c; bit d, e;
        select(4'b0100);
        coin(1'b0, 1'b1);
        n = 0;
        while (bus.timeout !== 1'b1 && n < TO + 4) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== TO) $display("FAIL timeout_delay: got %0d cycles expected %0d", n, TO); else n_pass++;
        count_train(p, c, d, e);
        n_checks++;
        if (p !== 2 || e) $display("FAIL timeout_refund: got pulses=%0d expected 2", p); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        select(4'b1000);
        repeat (3) coin(1'b1, 1'b0);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({bus.dispense, bus.rs_5_out, bus.coin_reject, bus.sel_error, bus.busy, bus.timeout} !== 6'd0
            || bus.credit !== 4'd0)
            $display("FAIL reset_mid: got outs=%b credit=%0d expected 000000 credit=0",
                     {bus.dispense, bus.rs_5_out, bus.coin_reject, bus.sel_error, bus.busy, bus.timeout}, bus.credit);
        else n_pass++;
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if (bus.rs_5_out !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_mid_after: got rs5=%b busy=%b expected 0 0", bus.rs_5_out, bus.busy);
        else n_pass++;
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        reset            = 1'b0;
        bus.item_number  = 4'd0;
        bus.item_valid   = 1'b0;
        bus.rs_5_in      = 1'b0;
        bus.rs_10_in     = 1'b0;
        bus.cancel       = 1'b0;
        bus.dispense_ack = 1'b0;
        test_reset();
        test_exact_pay();
        test_change();
        test_refund();
        test_errors();
        test_dual_coin_ack_hold();
        test_random();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
